// File: rtl/multiplier_datapath.sv
// -----------------------------------------------------------------------------
// multiplier_datapath
//
// Shift-add datapath for an unsigned N x N sequential multiplier. A companion
// sequencer drives one-hot control strobes; this block holds the working
// register {C, A, Q}, the latched multiplicand M and the iteration counter.
// It feeds `register` and `count` back to the sequencer and presents the
// finished product.
//
// Parameters:
//   N   operand width in bits
//   CW  counter width; must be able to hold the value N
//
// Ports:
//   clk            rising-edge clock for all state
//   reset          asynchronous, active-high; clears all state
//   multiplicand   operand M, sampled while RESET is high
//   multiplier     operand Q, sampled while RESET is high
//   RESET          load strobe (sequencer Idle state)
//   ADD            {C,A} <= A + M
//   SHIFT          {C,A,Q} logical right shift by one
//   DECREMENT      count <= count - 1, saturating at 0
//   READY          sequencer Stop state; product is final
//   register       {C, A, Q}; bit 0 is the current multiplier LSB
//   count          remaining iterations
//   product        {A, Q}
//   product_valid  one-cycle pulse when the product register is loaded
//
// Configuration macro: MULT_PRODUCT_REG_EN
//   defined     -> product is registered on the rising edge of READY and
//                  product_valid pulses for one cycle at that load
//   undefined   -> product = {A, Q} combinationally, product_valid = 0,
//                  READY is unused
// -----------------------------------------------------------------------------
module multiplier_datapath #(
  parameter int N  = 4,
  parameter int CW = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  input  logic           RESET,
  input  logic           ADD,
  input  logic           SHIFT,
  input  logic           DECREMENT,
  input  logic           READY,
  output logic [2*N:0]   register,
  output logic [CW-1:0]  count,
  output logic [2*N-1:0] product,
  output logic           product_valid
);

  // ---------------------------------------------------------------------------
  // Working state
  // ---------------------------------------------------------------------------
  logic          c_q,     c_d;
  logic [N-1:0]  a_q,     a_d;
  logic [N-1:0]  q_q,     q_d;
  logic [N-1:0]  m_q,     m_d;
  logic [CW-1:0] count_q, count_d;

  // N+1-bit sum so the carry out of A lands in C.
  logic [N:0] sum;
  assign sum = {1'b0, a_q} + {1'b0, m_q};

  // ---------------------------------------------------------------------------
  // Next-state logic. Priority is RESET > SHIFT > ADD; DECREMENT runs on its
  // own but is swallowed by a load.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block is given a hold value first, so no
    // path through the if/else chain can leave one unassigned (no latches).
    c_d     = c_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    count_d = count_q;

    if (RESET) begin
      c_d     = 1'b0;
      a_d     = '0;
      q_d     = multiplier;
      m_d     = multiplicand;
      count_d = CW'(N);
    end else begin
      if (SHIFT) begin
        // Logical right shift: old C enters A[N-1], A[0] enters Q[N-1].
        {c_d, a_d, q_d} = {1'b0, c_q, a_q, q_q[N-1:1]};
      end else if (ADD) begin
        // Q[0] is not re-checked here; the sequencer gates ADD with it.
        {c_d, a_d} = sum;
      end

      // Saturate at zero so a stray decrement never wraps to 2^CW-1.
      if (DECREMENT && (count_q != '0)) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: M is cleared along with the rest so an aborted multiply leaves
      // nothing behind; it is a handful of flops, not a memory array.
      c_q     <= 1'b0;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values computed above, independent of statement order.
      c_q     <= c_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      count_q <= count_d;
    end
  end

  assign register = {c_q, a_q, q_q};
  assign count    = count_q;

  // ---------------------------------------------------------------------------
  // Product presentation
  // ---------------------------------------------------------------------------
`ifdef MULT_PRODUCT_REG_EN
  logic           ready_d;
  logic           capture;
  logic [2*N-1:0] product_q;
  logic           product_valid_q;

  // First cycle of Stop: READY high now, low on the previous cycle.
  assign capture = READY & ~ready_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_d         <= 1'b0;
      product_q       <= '0;
      product_valid_q <= 1'b0;
    end else begin
      ready_d         <= READY;
      product_valid_q <= capture;
      // Holds through the next multiply until the next capture.
      if (capture) begin
        product_q <= {a_q, q_q};
      end
    end
  end

  assign product       = product_q;
  assign product_valid = product_valid_q;
`else
  // READY has no role without the product register.
  logic ready_unused;
  assign ready_unused  = READY;

  assign product       = {a_q, q_q};
  assign product_valid = 1'b0;
`endif

endmodule

// File: tb/tb_multiplier_datapath.sv
// -----------------------------------------------------------------------------
// tb_multiplier_datapath
//
// Directed bench for multiplier_datapath (N=4, CW=3). A small sequencer task
// drives the Load / Add / Shift / Stop strobes; each finished multiply pushes
// its hand-computed product into a queue and a separate monitor pops and
// compares whenever the DUT presents a product (product_valid with the
// product register, READY otherwise).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_multiplier_datapath;

  localparam int N  = 4;
  localparam int CW = 3;

  typedef struct {
    logic [2*N-1:0] product;
    int             id;
  } exp_t;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   multiplicand;
  logic [N-1:0]   multiplier;
  logic           RESET, ADD, SHIFT, DECREMENT, READY;
  logic [2*N:0]   register;
  logic [CW-1:0]  count;
  logic [2*N-1:0] product;
  logic           product_valid;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  multiplier_datapath #(.N(N), .CW(CW)) dut (
    .clk           (clk),
    .reset         (reset),
    .multiplicand  (multiplicand),
    .multiplier    (multiplier),
    .RESET         (RESET),
    .ADD           (ADD),
    .SHIFT         (SHIFT),
    .DECREMENT     (DECREMENT),
    .READY         (READY),
    .register      (register),
    .count         (count),
    .product       (product),
    .product_valid (product_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Advance one clock; return 1ns after the edge so state has settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_strobes();
    RESET = 1'b0; ADD = 1'b0; SHIFT = 1'b0; DECREMENT = 1'b0; READY = 1'b0;
  endtask

  // Sequencer model. ADD is gated by the bench's own copy of the multiplier
  // bit for each iteration. probe_iter >= 0 checks `register` after that
  // iteration's Add cycle; abort_iter >= 0 pulses async reset during that
  // iteration's Add cycle and abandons the multiply.
  task automatic run_multiply(input int id, input logic [N-1:0] m,
                              input logic [N-1:0] q, input logic [2*N-1:0] exp_p,
                              input int probe_iter, input logic [2*N:0] probe_val,
                              input int abort_iter);
    exp_t e;
    if (abort_iter < 0) begin
      e.product = exp_p;
      e.id      = id;
      exp_q.push_back(e);
    end
    idle_strobes();
    multiplicand = m;
    multiplier   = q;
    RESET        = 1'b1;
    tick();
    RESET = 1'b0;
    for (int i = 0; i < N; i++) begin
      ADD       = q[i];
      DECREMENT = 1'b1;
      SHIFT     = 1'b0;
      if (i == abort_iter) begin
        #1 reset = 1'b1;
        #1;
        check("abort_register_async", 32'(register), 32'h0);
        check("abort_count_async", 32'(count), 32'h0);
        tick();
        idle_strobes();
        reset = 1'b0;
        tick();
        return;
      end
      tick();
      if (i == probe_iter) check("probe_register", 32'(register), 32'(probe_val));
      ADD       = 1'b0;
      DECREMENT = 1'b0;
      SHIFT     = 1'b1;
      tick();
      SHIFT = 1'b0;
    end
    READY = 1'b1;
    tick();
    READY = 1'b0;
    tick();
    tick();
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: compares whenever the DUT presents a product.
  // ---------------------------------------------------------------------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
`ifdef MULT_PRODUCT_REG_EN
      if (product_valid === 1'b1) begin
`else
      if (READY === 1'b1) begin
`endif
        if (exp_q.size() == 0) begin
          check("unexpected_product", 32'(product), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("product_%0d", e.id), 32'(product), 32'(e.product));
          check($sformatf("final_carry_%0d", e.id), 32'(register[2*N]), 32'h0);
          check($sformatf("final_count_%0d", e.id), 32'(count), 32'h0);
`ifdef MULT_PRODUCT_REG_EN
          @(negedge clk);
          check($sformatf("valid_single_pulse_%0d", e.id), 32'(product_valid), 32'h0);
`endif
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [N-1:0]   m_tab [8] = '{4'd13, 4'd15, 4'd0, 4'd9, 4'd1,  4'd8, 4'd15, 4'd5};
  logic [N-1:0]   q_tab [8] = '{4'd11, 4'd15, 4'd9, 4'd0, 4'd15, 4'd8, 4'd1,  4'd3};
  logic [2*N-1:0] p_tab [8] = '{8'd143, 8'd225, 8'd0, 8'd0, 8'd15, 8'd64, 8'd15, 8'd15};

  initial begin
    idle_strobes();
    multiplicand = '0;
    multiplier   = '0;
    reset        = 1'b1;
    tick();
    tick();
    check("reset_register", 32'(register), 32'h0);
    check("reset_count", 32'(count), 32'h0);
    check("reset_product", 32'(product), 32'h0);
    check("reset_product_valid", 32'(product_valid), 32'h0);
    reset = 1'b0;
    tick();

    // Counter: load, then RESET+DECREMENT (load wins), then saturate.
    RESET = 1'b1;
    tick();
    check("count_after_load", 32'(count), 32'd4);
    DECREMENT = 1'b1;
    tick();
    check("count_reset_beats_decrement", 32'(count), 32'd4);
    RESET = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check($sformatf("count_dec_%0d", i), 32'(count), 32'((4 - i) < 0 ? 0 : (4 - i)));
    end
    idle_strobes();

    // SHIFT and ADD together: shift only. A=0, Q=0011, M=5 -> 0_0000_0001.
    multiplicand = 4'd5;
    multiplier   = 4'b0011;
    RESET        = 1'b1;
    tick();
    RESET = 1'b0;
    SHIFT = 1'b1;
    ADD   = 1'b1;
    tick();
    check("shift_beats_add", 32'(register), 32'h001);
    idle_strobes();
    tick();
    check("no_strobe_hold", 32'(register), 32'h001);

    // Full multiplies. 15x15 is probed after its 2nd add: {C,A,Q}=1_0110_1111.
    for (int v = 0; v < 8; v++) begin
      run_multiply(v, m_tab[v], q_tab[v], p_tab[v],
                   (v == 1) ? 1 : -1, 9'h16F, -1);
    end

    // Abort 13x11 on its 3rd Add cycle, then a fresh 6x7.
    run_multiply(100, 4'd13, 4'd11, 8'd143, -1, '0, 2);
    run_multiply(101, 4'd6, 4'd7, 8'd42, -1, '0, -1);

    tick();
    tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
